// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline sequencing logic.
//   state_t  : controller state encoding (ST_RUN = 0, ST_HALT = 1)
//   REG_W    : register address width
//   ZERO_REG : architectural zero register; never a real data producer
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_W    = 5;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Pure combinational load-use comparator.
// Ports:
//   id_rs, id_rt         : source register fields of the instruction in ID
//   id_use_rs, id_use_rt : ID instruction actually reads that source
//   ex_mem_read          : instruction in EX is a load
//   ex_rd                : destination register of the instruction in EX
//   lu                   : load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int REG_W = cpu_pkg::REG_W
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs && (id_rs == ex_rd);
    assign rt_hit = id_use_rt && (id_rt == ex_rd);

    // A load into the zero register produces nothing to wait for.
    assign lu = ex_mem_read && (ex_rd != REG_W'(ZERO_REG)) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Central sequencing controller for the 5-stage pipeline. Produces the
// advance (go) and bubble (clear) strobes for IF_ID, ID_EXE, EXE_MEM and
// MEM_WB plus the PC enable; handles load-use interlock, taken-branch/jump
// flush and syscall halt/resume.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds performance counters).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   id_rs/id_rt/id_use_rs/id_use_rt : ID source operands
//   ex_mem_read, ex_rd        : load in EX and its destination
//   ex_redirect               : taken branch/jump resolved in EX
//   wb_halt                   : syscall-halt instruction retiring in WB
//   resume                    : one-cycle pulse leaving HALT
//   pc_go .. mem_wb_go        : per-buffer advance enables
//   if_id_clear, id_ex_clear  : per-buffer load-zero strobes
//   halted                    : controller in HALT
//   cyc_cnt/stall_cnt/flush_cnt/halt_cnt : perf counters (macro only)
//   state                     : debug view of the state register
// Handshake note: there is no valid/ready pairing here; every strobe is a
// level that applies to the current clock edge only, and a clear is only
// ever raised together with go on the same buffer so the buffer loads zero.
// ---------------------------------------------------------------------------
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W = cpu_pkg::REG_W
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    input  logic             resume,
    output logic             pc_go,
    output logic             if_id_go,
    output logic             id_ex_go,
    output logic             ex_mem_go,
    output logic             mem_wb_go,
    output logic             if_id_clear,
    output logic             id_ex_clear,
    output logic             halted,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] halt_cnt,
`endif
    output state_t           state
);

    state_t state_q;
    logic   lu;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .lu          (lu)
    );

    // Qualified events in RUN, already resolved by priority.
    logic in_run;
    logic ev_halt;
    logic ev_flush;
    logic ev_stall;

    assign in_run   = (state_q == ST_RUN);
    assign ev_halt  = in_run && wb_halt;
    assign ev_flush = in_run && !wb_halt && ex_redirect;
    assign ev_stall = in_run && !wb_halt && !ex_redirect && lu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (wb_halt) state_q <= ST_HALT;
                // wb_halt is ignored here: the frozen WB must not retire twice.
                ST_HALT: if (resume)  state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        pc_go       = 1'b1;
        if_id_go    = 1'b1;
        id_ex_go    = 1'b1;
        ex_mem_go   = 1'b1;
        mem_wb_go   = 1'b1;
        if_id_clear = 1'b0;
        id_ex_clear = 1'b0;
        halted      = 1'b0;
        // Reset gates the decode so outputs read "free-running" with no
        // clock edge, even while the state register is still settling.
        if (!rst) begin
            if (!in_run) begin
                pc_go     = 1'b0;
                if_id_go  = 1'b0;
                id_ex_go  = 1'b0;
                ex_mem_go = 1'b0;
                mem_wb_go = 1'b0;
                halted    = 1'b1;
            end else if (ev_flush) begin
                // Squash the two wrong-path instructions in IF_ID and ID_EXE.
                if_id_clear = 1'b1;
                id_ex_clear = 1'b1;
            end else if (ev_stall) begin
                // Hold PC and IF_ID one cycle; the load leaves EX meanwhile.
                pc_go       = 1'b0;
                if_id_go    = 1'b0;
                id_ex_clear = 1'b1;
            end
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            halt_cnt  <= '0;
        end else begin
            if (in_run)   cyc_cnt   <= cyc_cnt + 1'b1;
            if (ev_stall) stall_cnt <= stall_cnt + 1'b1;
            if (ev_flush) flush_cnt <= flush_cnt + 1'b1;
            if (ev_halt)  halt_cnt  <= halt_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed testbench for hazard_ctrl. Outputs are packed as
// {pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go, if_id_clear,
//  id_ex_clear, halted} and compared against hand-computed patterns.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    import cpu_pkg::*;

    localparam logic [7:0] O_GO    = 8'b11111_00_0;
    localparam logic [7:0] O_REDIR = 8'b11111_11_0;
    localparam logic [7:0] O_LU    = 8'b00111_01_0;
    localparam logic [7:0] O_HALT  = 8'b00000_00_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_mem_read, ex_redirect, wb_halt, resume;
    logic       pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go;
    logic       if_id_clear, id_ex_clear, halted;
    state_t     state;

    int n_pass  = 0;
    int n_total = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt, halt_cnt;
    logic [3:0]  s_cyc, s_stall, s_flush, s_halt;
    logic        s_pc_go, s_if_id_go, s_id_ex_go, s_ex_mem_go, s_mem_wb_go;
    logic        s_if_id_clear, s_id_ex_clear, s_halted;
    state_t      s_state;
`endif

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .wb_halt(wb_halt), .resume(resume),
        .pc_go(pc_go), .if_id_go(if_id_go), .id_ex_go(id_ex_go),
        .ex_mem_go(ex_mem_go), .mem_wb_go(mem_wb_go),
        .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear), .halted(halted),
`ifdef HAZARD_PERF_CNT_EN
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .halt_cnt(halt_cnt),
`endif
        .state(state)
    );

`ifdef HAZARD_PERF_CNT_EN
    hazard_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .wb_halt(wb_halt), .resume(resume),
        .pc_go(s_pc_go), .if_id_go(s_if_id_go), .id_ex_go(s_id_ex_go),
        .ex_mem_go(s_ex_mem_go), .mem_wb_go(s_mem_wb_go),
        .if_id_clear(s_if_id_clear), .id_ex_clear(s_id_ex_clear), .halted(s_halted),
        .cyc_cnt(s_cyc), .stall_cnt(s_stall), .flush_cnt(s_flush), .halt_cnt(s_halt),
        .state(s_state)
    );
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] outs();
        return {pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go,
                if_id_clear, id_ex_clear, halted};
    endfunction

    // Sample combinational outputs 1 time unit after the inputs settle.
    task automatic chk_out(input string tag, input logic [7:0] exp);
        #1;
        check(tag, 32'(outs()), 32'(exp));
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        check(tag, 32'(state), 32'(exp));
    endtask

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; ex_redirect = 1'b0;
        wb_halt = 1'b0; resume = 1'b0;
    endtask

    task automatic drive_lu(input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt,
                            input logic rd_load, input logic [4:0] rd);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ex_mem_read = rd_load; ex_rd = rd;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 1'b1;
        // A load-use pattern during reset must not stall.
        drive_lu(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8);
        chk_out("reset_outputs", O_GO);
        chk_state("reset_state", ST_RUN);
        cyc();
        idle();
        rst = 1'b0;
        cyc();

        chk_out("run_idle", O_GO);

        drive_lu(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8);
        chk_out("lu_rs", O_LU);
        cyc();

        drive_lu(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0);
        chk_out("lu_rd_zero", O_GO);
        drive_lu(5'd3, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9);
        chk_out("lu_rt", O_LU);
        drive_lu(5'd8, 5'd9, 1'b0, 1'b1, 1'b1, 5'd8);
        chk_out("lu_rs_unused", O_GO);
        drive_lu(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8);
        chk_out("lu_not_load", O_GO);

        // Redirect beats a simultaneous load-use.
        drive_lu(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8);
        ex_redirect = 1'b1;
        chk_out("redirect_over_lu", O_REDIR);
        cyc();
        idle();

        resume = 1'b1;
        chk_out("resume_in_run", O_GO);
        cyc();
        resume = 1'b0;
        chk_state("resume_in_run_state", ST_RUN);

        // wb_halt has top priority: WB retires this cycle.
        wb_halt = 1'b1;
        ex_redirect = 1'b1;
        chk_out("halt_entry_cycle", O_GO);
        cyc();
        idle();
        chk_out("halt_frozen", O_HALT);
        chk_state("halt_state", ST_HALT);
`ifdef HAZARD_PERF_CNT_EN
        check("halt_cnt_one", halt_cnt, 32'd1);
`endif

        // Frozen redirect and load-use are ignored for 5 HALT cycles.
        ex_redirect = 1'b1;
        drive_lu(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8);
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("halt_hold_%0d", i), O_HALT);
            cyc();
        end

        wb_halt = 1'b1;
        chk_out("wb_halt_in_halt", O_HALT);
        cyc();
        wb_halt = 1'b0;
        chk_state("still_halt", ST_HALT);
`ifdef HAZARD_PERF_CNT_EN
        check("halt_cnt_unchanged", halt_cnt, 32'd1);
`endif

        resume = 1'b1;
        chk_out("resume_cycle", O_HALT);
        cyc();
        resume = 1'b0;
        chk_state("after_resume", ST_RUN);
        chk_out("redirect_after_resume", O_REDIR);
        cyc();
        idle();

        // Asynchronous reset mid-HALT.
        wb_halt = 1'b1;
        cyc();
        wb_halt = 1'b0;
        chk_out("halt_again", O_HALT);
        rst = 1'b1;
        chk_out("async_reset_outputs", O_GO);
        rst = 1'b0;
        #1;
        chk_state("async_reset_state", ST_RUN);
        cyc();
        chk_out("run_after_reset", O_GO);

`ifdef HAZARD_PERF_CNT_EN
        // Wrap test: 17 cycles on a 4-bit counter.
        idle();
        pulse_reset();
        repeat (17) cyc();
        check("cyc_cnt_17", cyc_cnt, 32'd17);
        check("cyc_cnt_wrap", 32'(s_cyc), 32'd1);

        // 100 cycles with 3 load-use stalls and 2 redirects.
        pulse_reset();
        for (int i = 0; i < 100; i++) begin
            idle();
            if (i == 10 || i == 30 || i == 50)
                drive_lu(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4);
            if (i == 20 || i == 60)
                ex_redirect = 1'b1;
            cyc();
        end
        idle();
        check("cyc_cnt_100", cyc_cnt, 32'd100);
        check("stall_cnt_3", stall_cnt, 32'd3);
        check("flush_cnt_2", flush_cnt, 32'd2);
        check("halt_cnt_0", halt_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
